// File: rtl/reg_mem_arb_if.sv
// Requester A/B ports and reg_mem bus of the two-port register-memory arbiter.
// The master side is the requesters plus the memory; the slave side is the arbiter.
interface reg_mem_arb_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_BITS  = 5
) ();
  logic                  req_a;
  logic                  we_a;
  logic [ADDR_BITS-1:0]  addr_a;
  logic [DATA_WIDTH-1:0] wdata_a;
  logic                  gnt_a;
  logic                  rvalid_a;
  logic [DATA_WIDTH-1:0] rdata_a;

  logic                  req_b;
  logic                  we_b;
  logic [ADDR_BITS-1:0]  addr_b;
  logic [DATA_WIDTH-1:0] wdata_b;
  logic                  gnt_b;
  logic                  rvalid_b;
  logic [DATA_WIDTH-1:0] rdata_b;

  logic [ADDR_BITS-1:0]  mem_addr;
  logic [DATA_WIDTH-1:0] mem_data_in;
  logic                  mem_wen;
  logic [DATA_WIDTH-1:0] mem_data_out;
  logic                  busy;

  modport master (
    output req_a, we_a, addr_a, wdata_a, req_b, we_b, addr_b, wdata_b, mem_data_out,
    input  gnt_a, rvalid_a, rdata_a, gnt_b, rvalid_b, rdata_b,
    input  mem_addr, mem_data_in, mem_wen, busy
  );

  modport slave (
    input  req_a, we_a, addr_a, wdata_a, req_b, we_b, addr_b, wdata_b, mem_data_out,
    output gnt_a, rvalid_a, rdata_a, gnt_b, rvalid_b, rdata_b,
    output mem_addr, mem_data_in, mem_wen, busy
  );
endinterface

// File: rtl/reg_mem_arb.sv
// Round-robin arbiter giving two requesters access to a single-port reg_mem.
// Define REG_MEM_ARB_CLEAR_EN to zero the whole memory after every reset.
module reg_mem_arb #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_BITS  = 5
) (
  input logic          clk,
  input logic          rst_n,
  reg_mem_arb_if.slave bus
);

`ifdef REG_MEM_ARB_CLEAR_EN
  typedef enum logic [1:0] {IDLE, RD_WAIT, CLEAR} state_t;
  localparam state_t RESET_STATE = CLEAR;
`else
  typedef enum logic [1:0] {IDLE, RD_WAIT} state_t;
  localparam state_t RESET_STATE = IDLE;
`endif

  state_t                state_reg, state_next;
  logic                  last_b_reg, last_b_next;
  logic                  rd_port_reg, rd_port_next;
  logic                  sel_b;
  logic                  sel_we;
  logic [ADDR_BITS-1:0]  addr_sel;
  logic [1:0]            gnt_vec;
  logic                  mem_wen_c;
  logic [ADDR_BITS-1:0]  mem_addr_c;
  logic [DATA_WIDTH-1:0] mem_data_c;
  logic                  busy_c;

`ifdef REG_MEM_ARB_CLEAR_EN
  logic [ADDR_BITS-1:0]  clr_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_cnt_reg <= '0;
    end else if (state_reg == CLEAR) begin
      clr_cnt_reg <= clr_cnt_reg + ADDR_BITS'(1);
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= RESET_STATE;
      last_b_reg  <= 1'b1;
      rd_port_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      last_b_reg  <= last_b_next;
      rd_port_reg <= rd_port_next;
    end
  end

  // Every output is gated by rst_n so that reset clears them without waiting for a clock.
  always_comb begin
    state_next   = state_reg;
    last_b_next  = last_b_reg;
    rd_port_next = rd_port_reg;
    sel_b        = 1'b0;
    sel_we       = 1'b0;
    addr_sel     = '0;
    gnt_vec      = 2'b00;
    mem_wen_c    = 1'b0;
    mem_addr_c   = '0;
    mem_data_c   = '0;
    busy_c       = 1'b0;
    if (rst_n) begin
      case (state_reg)
        IDLE: begin
          if (bus.req_a || bus.req_b) begin
            // B wins only when alone or when A was served last.
            sel_b       = bus.req_b && (!bus.req_a || !last_b_reg);
            sel_we      = sel_b ? bus.we_b : bus.we_a;
            addr_sel    = sel_b ? bus.addr_b : bus.addr_a;
            gnt_vec     = sel_b ? 2'b10 : 2'b01;
            mem_wen_c   = sel_we;
            mem_addr_c  = addr_sel;
            mem_data_c  = sel_b ? bus.wdata_b : bus.wdata_a;
            last_b_next = sel_b;
            if (!sel_we) begin
              state_next   = RD_WAIT;
              rd_port_next = sel_b;
            end
          end
        end
        RD_WAIT: begin
          busy_c     = 1'b1;
          state_next = IDLE;
        end
`ifdef REG_MEM_ARB_CLEAR_EN
        CLEAR: begin
          busy_c     = 1'b1;
          mem_wen_c  = 1'b1;
          mem_addr_c = clr_cnt_reg;
          if (clr_cnt_reg == '1) begin
            state_next = IDLE;
          end
        end
`endif
        default: state_next = IDLE;
      endcase
    end
  end

  // Read data lands in the port's register at the end of RD_WAIT; rvalid follows one cycle later.
  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    logic                  done;
    logic                  rvalid_reg;
    logic [DATA_WIDTH-1:0] rdata_reg;

    assign done = (state_reg == RD_WAIT) && (rd_port_reg == 1'(gi));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rvalid_reg <= 1'b0;
        rdata_reg  <= '0;
      end else begin
        rvalid_reg <= done;
        if (done) begin
          rdata_reg <= bus.mem_data_out;
        end
      end
    end
  end

  assign bus.gnt_a       = gnt_vec[0];
  assign bus.gnt_b       = gnt_vec[1];
  assign bus.rvalid_a    = g_port[0].rvalid_reg;
  assign bus.rvalid_b    = g_port[1].rvalid_reg;
  assign bus.rdata_a     = g_port[0].rdata_reg;
  assign bus.rdata_b     = g_port[1].rdata_reg;
  assign bus.mem_wen     = mem_wen_c;
  assign bus.mem_addr    = mem_addr_c;
  assign bus.mem_data_in = mem_data_c;
  assign bus.busy        = busy_c;

endmodule

// File: tb/tb_reg_mem_arb.sv
// Directed bench for reg_mem_arb with a behavioural reg_mem (registered read).
// Also covers the clear sequencer when REG_MEM_ARB_CLEAR_EN is defined.
module tb_reg_mem_arb;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  logic [7:0] mem_model [32];
  logic       mem_filled;

  reg_mem_arb_if #(.DATA_WIDTH(8), .ADDR_BITS(5)) bus ();

  reg_mem_arb #(.DATA_WIDTH(8), .ADDR_BITS(5)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reg_mem model: starts full of 8'hFF, data out is valid the cycle after the address.
  always @(posedge clk) begin
    if (!mem_filled) begin
      for (int i = 0; i < 32; i++) mem_model[i] = 8'hFF;
      mem_filled = 1'b1;
    end
    bus.mem_data_out <= mem_model[bus.mem_addr];
    if (bus.mem_wen) mem_model[bus.mem_addr] = bus.mem_data_in;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    mem_filled = 1'b0;
    rst_n = 1'b0;
    bus.req_a = 1'b1; bus.we_a = 1'b1; bus.addr_a = 5'd5; bus.wdata_a = 8'h77;
    bus.req_b = 1'b1; bus.we_b = 1'b0; bus.addr_b = 5'd6; bus.wdata_b = 8'h00;
    #3;
    check("rst_gnt_a", 32'(bus.gnt_a), 0);
    check("rst_gnt_b", 32'(bus.gnt_b), 0);
    check("rst_mem_wen", 32'(bus.mem_wen), 0);
    check("rst_mem_addr", 32'(bus.mem_addr), 0);
    check("rst_mem_data", 32'(bus.mem_data_in), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_rvalid_a", 32'(bus.rvalid_a), 0);
    check("rst_rdata_a", 32'(bus.rdata_a), 0);
    bus.req_a = 1'b0; bus.req_b = 1'b0;
    step();
    step();
    rst_n = 1'b1;

`ifdef REG_MEM_ARB_CLEAR_EN
    bus.req_a = 1'b1; bus.we_a = 1'b0; bus.addr_a = 5'd31;
    for (int i = 0; i < 32; i++) begin
      #2;
      check($sformatf("clr%0d_addr", i), 32'(bus.mem_addr), 32'(i));
      check($sformatf("clr%0d_wen", i), 32'(bus.mem_wen), 1);
      check($sformatf("clr%0d_data", i), 32'(bus.mem_data_in), 0);
      check($sformatf("clr%0d_busy", i), 32'(bus.busy), 1);
      check($sformatf("clr%0d_gnt_a", i), 32'(bus.gnt_a), 0);
      step();
    end
    #2;
    check("clr_first_gnt_a", 32'(bus.gnt_a), 1);
    check("clr_rd_addr", 32'(bus.mem_addr), 31);
    step();
    bus.req_a = 1'b0;
    #2;
    check("clr_rd_busy", 32'(bus.busy), 1);
    step();
    #2;
    check("clr_rd_rvalid", 32'(bus.rvalid_a), 1);
    check("clr_rd_rdata", 32'(bus.rdata_a), 0);
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (32) step();
`endif

    // Both write continuously: A wins the first tie, then strict alternation.
    bus.req_a = 1'b1; bus.we_a = 1'b1; bus.addr_a = 5'd1; bus.wdata_a = 8'h11;
    bus.req_b = 1'b1; bus.we_b = 1'b1; bus.addr_b = 5'd2; bus.wdata_b = 8'h22;
    for (int k = 0; k < 4; k++) begin
      #2;
      check($sformatf("rr%0d_gnt_a", k), 32'(bus.gnt_a), (k % 2 == 0) ? 1 : 0);
      check($sformatf("rr%0d_gnt_b", k), 32'(bus.gnt_b), (k % 2 == 0) ? 0 : 1);
      check($sformatf("rr%0d_addr", k), 32'(bus.mem_addr), (k % 2 == 0) ? 1 : 2);
      check($sformatf("rr%0d_data", k), 32'(bus.mem_data_in), (k % 2 == 0) ? 32'h11 : 32'h22);
      check($sformatf("rr%0d_wen", k), 32'(bus.mem_wen), 1);
      step();
    end
    bus.req_a = 1'b0; bus.req_b = 1'b0;

    // A writes 2A to addr 3 then reads it back.
    bus.req_a = 1'b1; bus.we_a = 1'b1; bus.addr_a = 5'd3; bus.wdata_a = 8'h2A;
    #2;
    check("wr_gnt_a", 32'(bus.gnt_a), 1);
    check("wr_wen", 32'(bus.mem_wen), 1);
    check("wr_addr", 32'(bus.mem_addr), 3);
    check("wr_data", 32'(bus.mem_data_in), 32'h2A);
    step();
    bus.we_a = 1'b0;
    #2;
    check("rd_gnt_a", 32'(bus.gnt_a), 1);
    check("rd_wen", 32'(bus.mem_wen), 0);
    check("rd_busy_grant", 32'(bus.busy), 0);
    step();
    bus.req_a = 1'b0;
    #2;
    check("rd_wait_busy", 32'(bus.busy), 1);
    check("rd_wait_gnt_a", 32'(bus.gnt_a), 0);
    check("rd_wait_rvalid", 32'(bus.rvalid_a), 0);
    check("rd_wait_wen", 32'(bus.mem_wen), 0);
    step();
    #2;
    check("rd_rvalid_a", 32'(bus.rvalid_a), 1);
    check("rd_rdata_a", 32'(bus.rdata_a), 32'h2A);
    check("rd_busy_done", 32'(bus.busy), 0);
    step();
    #2;
    check("rd_rvalid_drop", 32'(bus.rvalid_a), 0);
    check("rd_rdata_hold", 32'(bus.rdata_a), 32'h2A);

    // B stores 5A at 7, then reads it while A streams writes.
    bus.req_b = 1'b1; bus.we_b = 1'b1; bus.addr_b = 5'd7; bus.wdata_b = 8'h5A;
    #2;
    check("b_wr_gnt_b", 32'(bus.gnt_b), 1);
    step();
    bus.we_b = 1'b0;
    bus.req_a = 1'b1; bus.we_a = 1'b1; bus.addr_a = 5'd4; bus.wdata_a = 8'h44;
    #2;
    check("mix1_gnt_a", 32'(bus.gnt_a), 1);
    check("mix1_gnt_b", 32'(bus.gnt_b), 0);
    step();
    #2;
    check("mix2_gnt_b", 32'(bus.gnt_b), 1);
    check("mix2_gnt_a", 32'(bus.gnt_a), 0);
    check("mix2_addr", 32'(bus.mem_addr), 7);
    check("mix2_wen", 32'(bus.mem_wen), 0);
    step();
    bus.req_b = 1'b0;
    #2;
    check("mix3_gnt_a", 32'(bus.gnt_a), 0);
    check("mix3_gnt_b", 32'(bus.gnt_b), 0);
    check("mix3_busy", 32'(bus.busy), 1);
    check("mix3_wen", 32'(bus.mem_wen), 0);
    step();
    #2;
    check("mix4_gnt_a", 32'(bus.gnt_a), 1);
    check("mix4_rvalid_b", 32'(bus.rvalid_b), 1);
    check("mix4_rdata_b", 32'(bus.rdata_b), 32'h5A);
    check("mix4_rvalid_a", 32'(bus.rvalid_a), 0);
    check("mix4_rdata_a", 32'(bus.rdata_a), 32'h2A);
    step();
    bus.req_a = 1'b0;

    // Reset during RD_WAIT aborts the read.
    bus.req_a = 1'b1; bus.we_a = 1'b0; bus.addr_a = 5'd3;
    #2;
    check("abort_gnt_a", 32'(bus.gnt_a), 1);
    step();
    bus.req_a = 1'b0;
    #2;
    check("abort_busy_pre", 32'(bus.busy), 1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(bus.busy), 0);
    check("abort_rdata_a", 32'(bus.rdata_a), 0);
    check("abort_rdata_b", 32'(bus.rdata_b), 0);
    check("abort_rvalid_a", 32'(bus.rvalid_a), 0);
    check("abort_mem_addr", 32'(bus.mem_addr), 0);
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #2;
      check($sformatf("abort_post%0d_rvalid_a", k), 32'(bus.rvalid_a), 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/reg_mem_arb.md
REG_MEM_ARB -- requirements
Module: reg_mem_arb

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, the width of every data bus.
REQ-002 The block SHALL have parameter ADDR_BITS, default 5, the width of every address bus (2^ADDR_BITS words).
REQ-003 The block SHALL have port clk  input  1  the single clock, rising edge active.
REQ-004 The block SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have, for x in {a,b}, port req_x  input  1  access request.
REQ-006 The block SHALL have, for x in {a,b}, port we_x  input  1  1 = write, 0 = read; qualifies req_x.
REQ-007 The block SHALL have, for x in {a,b}, port addr_x  input  ADDR_BITS  access address.
REQ-008 The block SHALL have, for x in {a,b}, port wdata_x  input  DATA_WIDTH  write data.
REQ-009 The block SHALL have, for x in {a,b}, port gnt_x  output  1  one-cycle pulse marking acceptance of the request.
REQ-010 The block SHALL have, for x in {a,b}, port rvalid_x  output  1  one-cycle pulse marking valid rdata_x.
REQ-011 The block SHALL have, for x in {a,b}, port rdata_x  output  DATA_WIDTH  registered read data.
REQ-012 The block SHALL have ports mem_addr  output  ADDR_BITS, mem_data_in  output  DATA_WIDTH and mem_wen  output  1, driving the reg_mem instance.
REQ-013 The block SHALL have port mem_data_out  input  DATA_WIDTH  reg_mem read data, valid the cycle after the address is sampled.
REQ-014 The block SHALL have port busy  output  1  high in CLEAR or RD_WAIT.

Function
REQ-015 The FSM SHALL have states CLEAR (macro only), IDLE and RD_WAIT.
REQ-016 In IDLE with any req_x high, the block SHALL grant exactly one requester that cycle: gnt_x=1, with mem_addr/mem_data_in driven combinationally from addr_x/wdata_x.
REQ-017 Arbitration SHALL be round-robin: when both request, grant the one not granted last; the last-grant pointer resets to B, so A wins the first tie.
REQ-018 A lone requester SHALL be granted in every IDLE cycle in which it requests (no idle gap between back-to-back writes).
REQ-019 A write grant SHALL assert mem_wen in the grant cycle only; the FSM stays in IDLE.
REQ-020 A read grant in cycle N SHALL hold mem_wen=0, move to RD_WAIT for cycle N+1, register mem_data_out into rdata_x at the end of N+1, and pulse rvalid_x in cycle N+2.
REQ-021 The FSM SHALL issue no grant in RD_WAIT; in cycle N+2 it is back in IDLE and may grant, so reads complete every 2 cycles.
REQ-022 Requesters SHALL hold req/we/addr/wdata stable until gnt_x; a req_x still high in the cycle after gnt_x is a new request.
REQ-023 With no grant, mem_wen SHALL be 0 and mem_addr, mem_data_in SHALL be 0.
REQ-024 rdata_x SHALL hold its value until the next read completing for x; rdata of the other port SHALL be unaffected.
REQ-025 Addresses SHALL be used unmodified; no wrap or range logic beyond ADDR_BITS truncation.

Reset
REQ-026 While rst_n=0, the block SHALL force gnt_a, gnt_b, rvalid_a, rvalid_b, mem_wen and busy to 0, and rdata_a, rdata_b, mem_addr and mem_data_in to 0, asynchronously.
REQ-027 Reset asserted during RD_WAIT SHALL abort the read: no rvalid pulse after release.
REQ-028 After release, the FSM SHALL enter CLEAR if the macro is defined, else IDLE.

Configuration
REQ-029 Macro REG_MEM_ARB_CLEAR_EN SHALL gate the clear sequencer.
REQ-030 With REG_MEM_ARB_CLEAR_EN defined, CLEAR SHALL write 0 to addresses 0..2^ADDR_BITS-1 ascending, one per cycle (32 cycles at default), with busy=1 and no grants, then enter IDLE.
REQ-031 Without REG_MEM_ARB_CLEAR_EN, the block SHALL have no CLEAR state and no clear counter, and busy SHALL reflect RD_WAIT only.

Verification
REQ-032 A writes 8'h2A to addr 3 then reads addr 3 -> gnt_a pulses, mem_wen=1 in the write-grant cycle only, rvalid_a=1 exactly 2 cycles after the read grant, rdata_a=8'h2A.
REQ-033 A and B both request writes continuously from reset -> grants alternate A,B,A,B with no idle cycle.
REQ-034 B holds read of addr 7 while A streams writes -> B is granted within 2 cycles; no grant occurs in RD_WAIT.
REQ-035 rst_n pulsed low during RD_WAIT -> all outputs go 0 immediately and no rvalid follows release.
REQ-036 With REG_MEM_ARB_CLEAR_EN defined, req_a held high from reset -> 32 zero writes to addrs 0..31, busy=1 throughout, first gnt_a in cycle 33, and a read of addr 31 returns 0.
